// File: rtl/mrnw_wrfifo_pkg.sv
//==============================================================================
// Module   : mrnw_wrfifo_pkg
// Brief    : Shared types and helpers for the 1rNw write-FIFO backpressure block
// Revision : 1.0
//==============================================================================
`default_nettype none

package mrnw_wrfifo_pkg;

  localparam int MAX_WRPT = 16;

  typedef enum logic [0:0] {
    BP_OFF = 1'b0,
    BP_ON  = 1'b1
  } bp_state_t;

  function automatic int fnum_wrds(input int bitfifo);
    return 1 << bitfifo;
  endfunction

  // Callers zero-extend their write vector to MAX_WRPT bits.
  function automatic logic [4:0] popcount(input logic [MAX_WRPT-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_WRPT; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mrnw_wrfifo_bpctl_if.sv
//==============================================================================
// Module   : mrnw_wrfifo_bpctl_if
// Brief    : Write/drain handshake bundle between upstream ports and the tracker
// Revision : 1.0
//==============================================================================
`default_nettype none

interface mrnw_wrfifo_bpctl_if #(
  parameter int NUMWRPT = 6,
  parameter int BITPCNT = 4
) ();

  logic [NUMWRPT-1:0] write;
  logic               drain_en;
  logic [BITPCNT-1:0] drain_cnt;
  logic [NUMWRPT-1:0] wr_bp;

  modport master (
    output write,
    output drain_en,
    input  drain_cnt,
    input  wr_bp
  );

  modport slave (
    input  write,
    input  drain_en,
    output drain_cnt,
    output wr_bp
  );

endinterface

`default_nettype wire

// File: rtl/mrnw_bp_delay.sv
//==============================================================================
// Module   : mrnw_bp_delay
// Brief    : DEPTH-stage backpressure delay line; DEPTH=0 is a plain wire
// Revision : 1.0
//==============================================================================
`default_nettype none

module mrnw_bp_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = ^{clk, rst, clr};
      assign q        = d;
    end else begin : g_pipe
      logic [DEPTH-1:0] r_pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_pipe <= '0;
        end else if (clr) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= DEPTH'({r_pipe, d});
        end
      end
      assign q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mrnw_wrfifo_bpctl.sv
//==============================================================================
// Module   : mrnw_wrfifo_bpctl
// Brief    : Write-FIFO occupancy tracker with hysteretic per-port backpressure.
//            Optional high-water mark enabled by MRNW_WRFIFO_HWM_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mrnw_wrfifo_bpctl
  import mrnw_wrfifo_pkg::*;
#(
  parameter int NUMWRPT = 6,
  parameter int NUMWTPT = 2,
  parameter int BITFIFO = 8,
  parameter int BPDELAY = 1,
  parameter int BITPCNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready,
  mrnw_wrfifo_bpctl_if.slave bus,
  input  logic [BITFIFO:0]   bp_hi,
  input  logic [BITFIFO:0]   bp_lo,
  input  logic [NUMWRPT-1:0] bp_msk,
  output logic [BITFIFO:0]   fifo_cnt,
  output logic               ovf_err
`ifdef MRNW_WRFIFO_HWM_EN
  ,
  output logic [BITFIFO:0]   hwm
`endif
);

  localparam int CW       = BITFIFO + 2;
  localparam int FNUMWRDS = fnum_wrds(BITFIFO);
  localparam logic [BITFIFO:0] FULL_CNT = (BITFIFO+1)'(FNUMWRDS);

  logic [BITFIFO:0] r_cnt;
  logic             r_ovf;
  logic [CW-1:0]    w_ecnt;
  logic [CW-1:0]    w_dcnt;
  logic [CW-1:0]    w_nxt;
  logic             w_ovf;
  logic [BITFIFO:0] w_cnt_sat;
  bp_state_t        r_bp_state;
  bp_state_t        w_bp_nxt;
  logic             w_bp_raw;
  logic             w_bp_q;

  // Only entries present at cycle start are drainable, so dcnt never exceeds r_cnt.
  assign w_ecnt    = CW'(popcount(MAX_WRPT'(bus.write)));
  assign w_dcnt    = bus.drain_en ? CW'(min_u(32'(r_cnt), 32'(NUMWTPT))) : '0;
  assign w_nxt     = {1'b0, r_cnt} + w_ecnt - w_dcnt;
  assign w_ovf     = (w_nxt > CW'(FNUMWRDS));
  assign w_cnt_sat = w_ovf ? FULL_CNT : w_nxt[BITFIFO:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (!ready) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_sat;
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bp_state <= BP_OFF;
    end else if (!ready) begin
      r_bp_state <= BP_OFF;
    end else begin
      r_bp_state <= w_bp_nxt;
    end
  end

  always_comb begin
    w_bp_nxt = r_bp_state;
    case (r_bp_state)
      BP_OFF:  if (r_cnt > bp_hi)  w_bp_nxt = BP_ON;
      BP_ON:   if (r_cnt <= bp_lo) w_bp_nxt = BP_OFF;
      default: w_bp_nxt = BP_OFF;
    endcase
  end

  // The resolved hysteresis decision for the current count feeds the delay line,
  // so the total count-to-bp latency is exactly BPDELAY cycles.
  always_comb begin
    w_bp_raw = (w_bp_nxt == BP_ON);
  end

  mrnw_bp_delay #(
    .DEPTH (BPDELAY)
  ) u_bp_delay (
    .clk (clk),
    .rst (rst),
    .clr (!ready),
    .d   (w_bp_raw),
    .q   (w_bp_q)
  );

  assign bus.wr_bp     = {NUMWRPT{w_bp_q}} & bp_msk;
  assign bus.drain_cnt = BITPCNT'(w_dcnt);
  assign fifo_cnt      = r_cnt;
  assign ovf_err       = r_ovf;

`ifdef MRNW_WRFIFO_HWM_EN
  logic [BITFIFO:0] r_hwm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hwm <= '0;
    end else if (!ready) begin
      r_hwm <= '0;
    end else if (w_cnt_sat > r_hwm) begin
      r_hwm <= w_cnt_sat;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

`default_nettype wire
